// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern link: FSM encoding and the default
// marker pattern that both the generator and the detector agree on.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10,
      DONE = 2'b11
   } seq_state_t;

   localparam logic [4:0] SEQ_PATTERN = 5'b01101;

endpackage

// File: rtl/sequence_generator_piso.sv
// Parallel-in serial-out register, MSB first; a shift feeds zeros into the LSB.
module piso_shift_reg #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [W-1:0] i_data,
   output logic         o_msb
);

   logic [W-1:0] r_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
      end else if (i_shift) begin
         r_shift <= {r_shift[W-2:0], 1'b0};
      end
   end

   assign o_msb = r_shift[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with
// an optional idle gap between repetitions, then pulses done for one cycle.
module sequence_generator
   import seq_pkg::*;
#(
   parameter int PAT_W = 5,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap_len,
   output logic             out_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

   seq_state_t       r_state;
   logic [PAT_W-1:0] r_pat;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_reps;
   logic [GAP_W-1:0] r_gap_len;
   logic [GAP_W-1:0] r_gap_cnt;

   logic             w_accept;
   logic             w_last_bit;
   logic             w_more;
   logic             w_reload_send;
   logic             w_reload_gap;
   logic             w_load;
   logic             w_shift;
   logic [PAT_W-1:0] w_load_data;
   logic             w_msb;

   assign w_accept      = (r_state == IDLE) && start;
   assign w_last_bit    = (r_state == SEND) && (r_idx == '0);
   assign w_more        = (r_reps > CNT_W'(1));
   assign w_reload_send = w_last_bit && w_more && (r_gap_len == '0) && !abort;
   assign w_reload_gap  = (r_state == GAP) && (r_gap_cnt == GAP_W'(1)) && !abort;

   // The shifter is reloaded from the captured copy at each new repetition.
   assign w_load      = w_accept || w_reload_send || w_reload_gap;
   assign w_load_data = w_accept ? pattern : r_pat;
   assign w_shift     = (r_state == SEND) && !w_load;

   piso_shift_reg #(
      .W (PAT_W)
   ) u_piso (
      .clk     (clk),
      .rst_n   (reset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_load_data),
      .o_msb   (w_msb)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_pat     <= '0;
         r_idx     <= '0;
         r_reps    <= '0;
         r_gap_len <= '0;
         r_gap_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_pat     <= pattern;
                  r_reps    <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                  r_gap_len <= gap_len;
                  r_idx     <= IDX_LAST;
                  r_state   <= SEND;
               end
            end
            SEND: begin
               if (abort) begin
                  r_state <= IDLE;
               end else if (r_idx != '0) begin
                  r_idx <= r_idx - IDX_W'(1);
               end else if (!w_more) begin
                  r_state <= DONE;
               end else if (r_gap_len == '0) begin
                  r_idx  <= IDX_LAST;
                  r_reps <= r_reps - CNT_W'(1);
               end else begin
                  r_gap_cnt <= r_gap_len;
                  r_state   <= GAP;
               end
            end
            GAP: begin
               if (abort) begin
                  r_state <= IDLE;
               end else if (r_gap_cnt == GAP_W'(1)) begin
                  r_idx   <= IDX_LAST;
                  r_reps  <= r_reps - CNT_W'(1);
                  r_state <= SEND;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from registers so reset clears them at once.
   assign out_valid = (r_state == SEND);
   assign out_bit   = out_valid && w_msb;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: framing, repeats, gaps, abort, reset.
module tb_sequence_generator;
   import seq_pkg::*;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic [4:0] pattern;
   logic [3:0] repeat_cnt;
   logic [2:0] gap_len;
   logic       out_bit;
   logic       out_valid;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] det_shift;

   sequence_generator #(
      .PAT_W (5),
      .CNT_W (4),
      .GAP_W (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .pattern    (pattern),
      .repeat_cnt (repeat_cnt),
      .gap_len    (gap_len),
      .out_bit    (out_bit),
      .out_valid  (out_valid),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Receiver-side view: the last five valid bits seen on the line.
   always @(posedge clk or negedge reset) begin
      if (!reset) det_shift <= '0;
      else if (out_valid) det_shift <= {det_shift[3:0], out_bit};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [4:0] pat, input logic [3:0] rep, input logic [2:0] gap);
      pattern    = pat;
      repeat_cnt = rep;
      gap_len    = gap;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      $display("[TB] start pattern=%b reps=%0d gap=%0d", pat, rep, gap);
   endtask

   // Checks n cycles of line activity (MSB of the vectors first), then the DONE pulse.
   task automatic run_check(input string tag, input logic [31:0] bits,
                            input logic [31:0] valid, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         chk({tag, "_valid"}, 32'(out_valid), 32'(valid[i]));
         chk({tag, "_bit"},   32'(out_bit),   32'(bits[i] & valid[i]));
         chk({tag, "_busy"},  32'(busy),      32'd1);
         chk({tag, "_nodone"},32'(done),      32'd0);
         tick();
      end
      chk({tag, "_done"},      32'(done),      32'd1);
      chk({tag, "_done_busy"}, 32'(busy),      32'd1);
      chk({tag, "_done_inv"},  32'(out_valid), 32'd0);
      tick();
      chk({tag, "_idle_done"}, 32'(done),      32'd0);
      chk({tag, "_idle_busy"}, 32'(busy),      32'd0);
      $display("[TB] %s transfer checked (%0d line cycles)", tag, n);
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      pattern    = '0;
      repeat_cnt = '0;
      gap_len    = '0;
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_bit",   32'(out_bit),   32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      reset = 1'b1;
      tick();
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single repetition of the shared marker, plus receiver loopback check.
      do_start(SEQ_PATTERN, 4'd1, 3'd0);
      run_check("single", 32'b01101, 32'b11111, 5);
      chk("loopback", 32'(det_shift), 32'(SEQ_PATTERN));

      // Three back-to-back repetitions, no bubble.
      do_start(5'b10011, 4'd3, 3'd0);
      run_check("b2b", 32'b100111001110011, 32'b111111111111111, 15);

      // Two repetitions separated by a 2-cycle gap.
      do_start(5'b01101, 4'd2, 3'd2);
      run_check("gap2", 32'b011010001101, 32'b111110011111, 12);

      // repeat_cnt=0 acts as 1; a start pulse mid-transfer is ignored.
      do_start(5'b10110, 4'd0, 3'd0);
      chk("rep0_b4", 32'(out_bit), 32'd1);
      pattern    = 5'b00000;
      repeat_cnt = 4'd3;
      start      = 1'b1;
      tick();
      chk("rep0_b3", 32'(out_bit), 32'd0);
      start      = 1'b0;
      tick();
      run_check("rep0", 32'b110, 32'b111, 3);
      tick();
      chk("rep0_norestart", 32'(busy), 32'd0);

      // Abort on the third bit of the first repetition.
      do_start(5'b01101, 4'd2, 3'd0);
      tick();
      tick();
      chk("abort_b2", 32'(out_bit), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy",  32'(busy),      32'd0);
      chk("abort_done",  32'(done),      32'd0);
      $display("[TB] abort checked");

      // start and abort together in IDLE: start wins.
      abort = 1'b1;
      do_start(5'b11000, 4'd1, 3'd0);
      abort = 1'b0;
      run_check("post_abort", 32'b11000, 32'b11111, 5);

      // Asynchronous reset in the middle of a gap.
      do_start(5'b01101, 4'd2, 3'd3);
      for (int i = 0; i < 6; i++) tick();
      chk("gap_valid", 32'(out_valid), 32'd0);
      chk("gap_busy",  32'(busy),      32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy",  32'(busy),      32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_bit",   32'(out_bit),   32'd0);
      chk("arst_done",  32'(done),      32'd0);
      #1;
      reset = 1'b1;
      tick();
      tick();
      chk("arst_idle",  32'(busy), 32'd0);
      chk("arst_nodone",32'(done), 32'd0);
      $display("[TB] async reset checked");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
